booth_csa_accum32: RTL

- Sequential radix-4 Booth multiplier front end for the 16x16 approximate multiplier path.
- Accepts two signed 16-bit operands and accumulates the 8 Booth partial products over 8 cycles in carry-save form, one product per cycle.
- Delivers a 32-bit sum vector and a 32-bit carry vector to the downstream 32-bit carry-select adder, which resolves the product with cin=0.
- Optional low-column truncation gives approximate operation.

---
 rtl/mul_appr_pkg.sv | 39 +++
 rtl/booth_pp_sel.sv | 31 +++
 rtl/booth_csa_accum32.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mul_appr_pkg.sv
// Shared definitions for the approximate 16x16 multiplier path.
//   OP_W / RES_W / NUM_PP : operand width, result width, Booth partial products
//   state_e               : sequencer states of the carry-save accumulator
//   booth_e               : radix-4 Booth digit selections
//   booth_decode()        : maps a 3-bit multiplier window to a Booth digit
package mul_appr_pkg;

  localparam int OP_W   = 16;
  localparam int RES_W  = 32;
  localparam int NUM_PP = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_PA   = 3'd1,
    BOOTH_P2A  = 3'd2,
    BOOTH_NA   = 3'd3,
    BOOTH_N2A  = 3'd4
  } booth_e;

  // Window bits are {B[2i+1], B[2i], B[2i-1]}.
  function automatic booth_e booth_decode(input logic [2:0] win);
    booth_e d;
    case (win)
      3'b001, 3'b010: d = BOOTH_PA;
      3'b011:         d = BOOTH_P2A;
      3'b100:         d = BOOTH_N2A;
      3'b101, 3'b110: d = BOOTH_NA;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector (combinational).
// Ports:
//   win_i  : 3-bit multiplier window {B[2i+1], B[2i], B[2i-1]}
//   a_i    : +A, sign-extended to RES_W
//   a2_i   : +2A, sign-extended to RES_W
//   na_i   : -A, sign-extended to RES_W
//   n2a_i  : -2A, sign-extended to RES_W
//   pp_o   : selected, unshifted partial product
module booth_pp_sel
  import mul_appr_pkg::*;
(
  input  logic        [2:0]       win_i,
  input  logic signed [RES_W-1:0] a_i,
  input  logic signed [RES_W-1:0] a2_i,
  input  logic signed [RES_W-1:0] na_i,
  input  logic signed [RES_W-1:0] n2a_i,
  output logic signed [RES_W-1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    case (booth_decode(win_i))
      BOOTH_PA:  pp_o = a_i;
      BOOTH_P2A: pp_o = a2_i;
      BOOTH_NA:  pp_o = na_i;
      BOOTH_N2A: pp_o = n2a_i;
      default:   pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_csa_accum32.sv
// Sequential radix-4 Booth multiplier front end. Accepts a signed 16x16
// operand pair, adds one Booth partial product per cycle into a carry-save
// (S, C) pair over 8 cycles, then presents S and C so that
// s_vec + c_vec (mod 2^32) equals the product. The low APPROX_COLS columns
// of every partial product are cleared for approximate operation.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operand handshake
//   in_a, in_b          : signed multiplicand / multiplier
//   out_valid/out_ready : result handshake towards the carry-select adder
//   s_vec, c_vec        : carry-save sum and carry vectors
module booth_csa_accum32
  import mul_appr_pkg::*;
#(
  parameter int APPROX_COLS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [OP_W-1:0]  in_a,
  input  logic signed [OP_W-1:0]  in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [RES_W-1:0] s_vec,
  output logic        [RES_W-1:0] c_vec
);

  localparam logic [RES_W-1:0] TRUNC_MASK =
    ~((RES_W'(1) << APPROX_COLS) - RES_W'(1));

  // Clears the approximated low columns of a partial product.
  function automatic logic [RES_W-1:0] trunc_cols(input logic [RES_W-1:0] p);
    return p & TRUNC_MASK;
  endfunction

  state_e                  state_q, state_d;
  logic        [2:0]       cnt_q, cnt_d;
  logic        [RES_W-1:0] s_q, s_d;
  logic        [RES_W-1:0] c_q, c_d;

  // Operand registers carry no reset: they are only read in RUN, which is
  // always entered through a load.
  logic        [OP_W:0]    b_q;      // {B, B[-1]=0}
  logic signed [RES_W-1:0] a_q, a2_q, na_q, n2a_q;

  logic                    accept;
  logic signed [OP_W+1:0]  a_x18;
  logic signed [OP_W+1:0]  a2_x18, na_x18, n2a_x18;
  logic        [2:0]       win;
  logic signed [RES_W-1:0] pp_raw;
  logic        [RES_W-1:0] pp;
  logic        [RES_W-1:0] s_nxt, c_nxt;

  assign out_valid = (state_q == DONE);
  assign s_vec     = s_q;
  assign c_vec     = c_q;

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  // 18 bits keep -(-32768) and -2*(-32768) representable before extension.
  assign a_x18   = {{2{in_a[OP_W-1]}}, in_a};
  assign a2_x18  = a_x18 <<< 1;
  assign na_x18  = -a_x18;
  assign n2a_x18 = -a2_x18;

  always_ff @(posedge clk) begin
    if (accept) begin
      b_q   <= {in_b, 1'b0};
      a_q   <= {{(RES_W-OP_W-2){a_x18[OP_W+1]}},   a_x18};
      a2_q  <= {{(RES_W-OP_W-2){a2_x18[OP_W+1]}},  a2_x18};
      na_q  <= {{(RES_W-OP_W-2){na_x18[OP_W+1]}},  na_x18};
      n2a_q <= {{(RES_W-OP_W-2){n2a_x18[OP_W+1]}}, n2a_x18};
    end
  end

  // Window for digit i starts at bit 2i of {B, 0}.
  assign win = b_q[{cnt_q, 1'b0} +: 3];

  booth_pp_sel u_pp_sel (
    .win_i (win),
    .a_i   (a_q),
    .a2_i  (a2_q),
    .na_i  (na_q),
    .n2a_i (n2a_q),
    .pp_o  (pp_raw)
  );

  assign pp = trunc_cols(pp_raw << {cnt_q, 1'b0});

  // 3:2 compression; the carry out of bit 31 falls off the shift.
  assign s_nxt = s_q ^ c_q ^ pp;
  assign c_nxt = ((s_q & c_q) | (s_q & pp) | (c_q & pp)) << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          s_d     = '0;
          c_d     = '0;
        end
      end
      RUN: begin
        s_d   = s_nxt;
        c_d   = c_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(NUM_PP - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          // A load on the transfer edge goes straight back to RUN.
          if (in_valid) begin
            state_d = RUN;
            cnt_d   = '0;
            s_d     = '0;
            c_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

endmodule
